// File: rtl/sliding_window_gen.sv
// Raster-to-3x3 window generator: two line buffers feed a 3x3 tap array.
// Ports: clk, rst (async high), pix_in/pix_valid/sof in; act, sw_pixel_1..9, busy out;
// sync_err out only when SYNC_ERR_EN is defined (sticky framing error flag).
module sliding_window_gen #(
  parameter int N     = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pix_in,
  input  logic         pix_valid,
  input  logic         sof,
  output logic         act,
  output logic [N-1:0] sw_pixel_1,
  output logic [N-1:0] sw_pixel_2,
  output logic [N-1:0] sw_pixel_3,
  output logic [N-1:0] sw_pixel_4,
  output logic [N-1:0] sw_pixel_5,
  output logic [N-1:0] sw_pixel_6,
  output logic [N-1:0] sw_pixel_7,
  output logic [N-1:0] sw_pixel_8,
  output logic [N-1:0] sw_pixel_9,
`ifdef SYNC_ERR_EN
  output logic         sync_err,
`endif
  output logic         busy
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          act_q, act_d;
  logic [N-1:0]  win_q [9];
  logic [N-1:0]  win_d [9];
  logic [N-1:0]  lb0_q [IMG_W];
  logic [N-1:0]  lb1_q [IMG_W];

  logic          acc;
  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic          col_last;
  logic          frame_end;
  logic          fill_end;

  // A sof pixel is always taken as (0,0), whatever the counters hold.
  assign acc       = pix_valid & (sof | (state_q != S_IDLE));
  assign c         = sof ? '0 : col_q;
  assign r         = sof ? '0 : row_q;
  assign col_last  = (c == CW'(IMG_W - 1));
  assign frame_end = col_last & (r == RW'(IMG_H - 1));
  assign fill_end  = col_last & (r == RW'(1));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    act_d   = 1'b0;
    win_d   = win_q;
    if (acc) begin
      act_d    = (r >= RW'(2)) && (c >= CW'(2));
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb1_q[c];
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb0_q[c];
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_in;
      if (col_last) begin
        col_d = '0;
        row_d = frame_end ? '0 : r + RW'(1);
      end else begin
        col_d = c + CW'(1);
        row_d = r;
      end
      unique case (1'b1)
        sof:       state_d = S_FILL;
        frame_end: state_d = S_IDLE;
        fill_end:  state_d = S_RUN;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      act_q   <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      act_q   <= act_d;
      win_q   <= win_d;
    end
  end

  // Line buffers need no reset: rows 0..1 of a frame rewrite every
  // column before any window reads them.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1_q[c] <= lb0_q[c];
      lb0_q[c] <= pix_in;
    end
  end

`ifdef SYNC_ERR_EN
  logic done_q, done_d;
  logic err_q, err_d;

  always_comb begin
    done_d = done_q | (acc & frame_end);
    err_d  = err_q
           | (pix_valid & sof & (state_q != S_IDLE))
           | (pix_valid & ~sof & (state_q == S_IDLE) & done_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign sync_err = err_q;
`endif

  assign act        = act_q;
  assign busy       = (state_q != S_IDLE);
  assign sw_pixel_1 = win_q[0];
  assign sw_pixel_2 = win_q[1];
  assign sw_pixel_3 = win_q[2];
  assign sw_pixel_4 = win_q[3];
  assign sw_pixel_5 = win_q[4];
  assign sw_pixel_6 = win_q[5];
  assign sw_pixel_7 = win_q[6];
  assign sw_pixel_8 = win_q[7];
  assign sw_pixel_9 = win_q[8];

endmodule

// File: tb/tb_sliding_window_gen.sv
// Scoreboard bench for sliding_window_gen at a 4x3 image.
// A frame-array model predicts windows, act timing, busy and sync_err.
module tb_sliding_window_gen;

  localparam int N = 8;
  localparam int W = 4;
  localparam int H = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] pix_in = '0;
  logic         pix_valid = 1'b0;
  logic         sof = 1'b0;
  logic         act, busy;
  logic [N-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
`ifdef SYNC_ERR_EN
  logic         sync_err;
`endif

  sliding_window_gen #(.N(N), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in),
    .pix_valid(pix_valid), .sof(sof), .act(act),
    .sw_pixel_1(p1), .sw_pixel_2(p2), .sw_pixel_3(p3),
    .sw_pixel_4(p4), .sw_pixel_5(p5), .sw_pixel_6(p6),
    .sw_pixel_7(p7), .sw_pixel_8(p8), .sw_pixel_9(p9),
`ifdef SYNC_ERR_EN
    .sync_err(sync_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [71:0] q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  act_cnt = 0;
  bit  mon_en = 1'b0;
  bit  exp_act = 1'b0;
  bit  exp_busy = 1'b0;
  bit  exp_err = 1'b0;

  logic [7:0] img [H][W];
  bit  in_frame = 1'b0;
  bit  done = 1'b0;
  int  mr = 0;
  int  mc = 0;

  function automatic logic [71:0] taps();
    return {p1, p2, p3, p4, p5, p6, p7, p8, p9};
  endfunction

  task automatic chk(input string nm, input logic [71:0] got,
                     input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Frame-level model: store each accepted pixel at its (row,col) and
  // emit the 3x3 neighbourhood ending at that pixel once row,col >= 2.
  task automatic model_step(input bit v, input bit s, input logic [7:0] p);
    bit a;
    a = 1'b0;
    exp_act = 1'b0;
    if (v) begin
      if (s) begin
        if (in_frame) exp_err = 1'b1;
        in_frame = 1'b1;
        mr = 0;
        mc = 0;
        a = 1'b1;
      end else if (in_frame) begin
        a = 1'b1;
      end else if (done) begin
        exp_err = 1'b1;
      end
    end
    if (a) begin
      img[mr][mc] = p;
      if (mr >= 2 && mc >= 2) begin
        q.push_back({img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                     img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                     img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]});
        exp_act = 1'b1;
      end
      if (mc == W - 1) begin
        mc = 0;
        if (mr == H - 1) begin
          mr = 0;
          in_frame = 1'b0;
          done = 1'b1;
        end else begin
          mr++;
        end
      end else begin
        mc++;
      end
    end
    exp_busy = in_frame;
  endtask

  task automatic beat(input bit v, input bit s, input logic [7:0] p);
    pix_valid = v;
    sof = s;
    pix_in = p;
    @(posedge clk);
    model_step(v, s, p);
    #1;
    pix_valid = 1'b0;
    sof = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    in_frame = 1'b0;
    done = 1'b0;
    mr = 0;
    mc = 0;
    exp_act = 1'b0;
    exp_busy = 1'b0;
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_taps", taps(), '0);
    rst = 1'b0;
  endtask

  // gap: 0 none, 1 every other cycle, 2 random. npix < W*H gives a
  // partial frame.
  task automatic send_frame(input int gap, input bit rnd, input int npix);
    for (int i = 0; i < npix; i++) begin
      int r, c;
      logic [7:0] p;
      r = i / W;
      c = i % W;
      p = rnd ? 8'($urandom) : {r[3:0], c[3:0]};
      if (gap == 1 && i > 0) beat(1'b0, 1'b0, 8'($urandom));
      if (gap == 2) repeat ($urandom_range(0, 2)) beat(1'b0, 1'b0, 8'($urandom));
      beat(1'b1, i == 0, p);
    end
  endtask

  task automatic expect_acts(input string nm, input int base, input int n);
    repeat (2) beat(1'b0, 1'b0, 8'h00);
    chk(nm, 72'(act_cnt - base), 72'(n));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("act", 72'(act), 72'(exp_act));
      chk("busy", 72'(busy), 72'(exp_busy));
`ifdef SYNC_ERR_EN
      chk("sync_err", 72'(sync_err), 72'(exp_err));
`endif
      if (act) begin
        act_cnt++;
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL window: got %h expected none", taps());
        end else begin
          chk("window", taps(), q.pop_front());
        end
      end
    end
  end

  initial begin
    int base;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    do_reset();

    // Reset mid-stream with a window about to be emitted.
    send_frame(0, 1'b1, 10);
    do_reset();
    repeat (5) beat(1'b1, 1'b0, 8'($urandom));
    base = act_cnt;
    send_frame(0, 1'b0, W * H);
    expect_acts("acts_after_reset", base, 2);

    // Full frame, no gaps.
    base = act_cnt;
    send_frame(0, 1'b0, W * H);
    expect_acts("acts_nogap", base, 2);

    // Same frame with a gap every other cycle.
    base = act_cnt;
    send_frame(1, 1'b0, W * H);
    expect_acts("acts_gap", base, 2);

    // Stray pixels before the first frame after reset.
    do_reset();
    repeat (4) beat(1'b1, 1'b0, 8'($urandom));
    base = act_cnt;
    send_frame(0, 1'b0, W * H);
    expect_acts("acts_stray", base, 2);

    // Resync: sof arrives at pixel (1,2).
    base = act_cnt;
    send_frame(0, 1'b1, W + 2);
    send_frame(0, 1'b1, W * H);
    expect_acts("acts_resync", base, 2);

    // Back-to-back frames.
    base = act_cnt;
    send_frame(0, 1'b1, W * H);
    send_frame(0, 1'b1, W * H);
    expect_acts("acts_b2b", base, 4);

    // Randomized mix of stray pixels, partial frames and gapped frames.
    for (int k = 0; k < 30; k++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) repeat ($urandom_range(1, 3)) beat(1'b1, 1'b0, 8'($urandom));
      else if (sel == 1) send_frame(2, 1'b1, $urandom_range(1, W * H - 1));
      else if (sel == 2 && k > 20) do_reset();
      else send_frame(2, 1'b1, W * H);
    end
    repeat (3) beat(1'b0, 1'b0, 8'h00);

    chk("pending", 72'(q.size()), 72'(0));
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
